// File: rtl/rx_frame_checker_pkg.sv
// rx_frame_checker_pkg: shared constants, types and the PRBS-9 byte-step
// helper used by the receive-side frame checker.
package rx_frame_checker_pkg;

    // PRBS-9 (x^9 + x^5 + 1): seed loaded at every frame start, tap positions
    localparam logic [8:0] PRBS9_SEED   = 9'h1FF;
    localparam int         PRBS9_TAP_HI = 8;
    localparam int         PRBS9_TAP_LO = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0] exp_byte;
        logic [8:0] next_state;
    } prbs9_step_t;

    // Runs the generator for eight bit-steps; the first bit out lands in the MSB
    function automatic prbs9_step_t prbs9_byte_step(input logic [8:0] state);
        logic [8:0]  lfsr;
        prbs9_step_t res;
        lfsr         = state;
        res.exp_byte = '0;
        for (int i = 7; i >= 0; i--) begin
            res.exp_byte[i] = lfsr[PRBS9_TAP_HI];
            lfsr = {lfsr[7:0], lfsr[PRBS9_TAP_HI] ^ lfsr[PRBS9_TAP_LO]};
        end
        res.next_state = lfsr;
        return res;
    endfunction

endpackage

// File: rtl/rx_frame_checker_prbs9_byte_gen.sv
// prbs9_byte_gen: combinational PRBS-9 reference, current LFSR state in,
// expected byte and the state after eight steps out.
module prbs9_byte_gen
    import rx_frame_checker_pkg::*;
(
    input  logic [8:0] state,
    output logic [7:0] exp_byte,
    output logic [8:0] next_state
);

    prbs9_step_t step;

    // One full byte of generator advance
    always_comb begin
        step = prbs9_byte_step(state);
    end

    assign exp_byte   = step.exp_byte;
    assign next_state = step.next_state;

endmodule

// File: rtl/rx_frame_checker.sv
// rx_frame_checker: checks received PRBS-9 frames from the Rx byte stream,
// counts bit errors and frame outcomes, and reports per-frame verdicts.
// Optional link-lock tracking is built when RX_FRAME_CHECKER_LOCK_EN is
// defined; otherwise lock is tied low.
module rx_frame_checker
    import rx_frame_checker_pkg::*;
#(
    parameter int FRAME_LEN = 32,
    parameter int CNT_W     = 16,
    parameter int LOCK_GOOD = 4,
    parameter int LOCK_BAD  = 2
) (
    input  logic             clk_1M024,
    input  logic             rst_n_1M024,
    input  logic             clr,
    input  logic [7:0]       s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    input  logic             s_tuser,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_bit_cnt,
    output logic             lock
);

    localparam logic [8:0]       FRAME_LEN_C = 9'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    // Out-of-range parameters would silently break the count/sum widths
    if (FRAME_LEN < 1 || FRAME_LEN > 255 || CNT_W < 4 ||
        LOCK_GOOD < 1 || LOCK_GOOD > 255 || LOCK_BAD < 1 || LOCK_BAD > 255) begin : g_param_check
        $error("rx_frame_checker: parameter out of range");
    end

    state_t      state;
    logic [8:0]  lfsr;
    logic [8:0]  byte_cnt;
    logic [10:0] err_sum;

    logic        frame_start;
    logic        in_frame;
    logic        compare_en;
    logic        abort_close;
    logic        overrun;
    logic        end_close;
    logic        end_ok;
    logic        good_inc;
    logic [1:0]  close_cnt;
    logic [8:0]  gen_state;
    logic [8:0]  gen_next;
    logic [7:0]  exp_byte;
    logic [3:0]  byte_errs;
    logic [8:0]  cnt_next;
    logic [10:0] sum_next;

    // A byte with tuser always restarts the reference from the seed
    assign frame_start = s_tvalid & s_tuser;
    assign in_frame    = (state == ST_PAYLOAD);
    assign gen_state   = frame_start ? PRBS9_SEED : lfsr;

    prbs9_byte_gen u_prbs9 (
        .state      (gen_state),
        .exp_byte   (exp_byte),
        .next_state (gen_next)
    );

    // Only bytes belonging to a frame are compared; stray bytes in IDLE are dropped
    assign compare_en  = s_tvalid & (s_tuser | in_frame);
    assign byte_errs   = 4'($countones(s_tdata ^ exp_byte));
    assign cnt_next    = (frame_start ? 9'd0 : byte_cnt) + 9'd1;
    assign sum_next    = (frame_start ? 11'd0 : err_sum) + {7'd0, byte_errs};

    // A new tuser inside a frame aborts the running frame as bad
    assign abort_close = frame_start & in_frame;
    // A full-length frame that keeps going without tlast is an overrun
    assign overrun     = s_tvalid & ~s_tuser & ~s_tlast & in_frame & (byte_cnt == FRAME_LEN_C);
    assign end_close   = compare_en & (s_tlast | overrun);
    assign end_ok      = s_tlast & (cnt_next == FRAME_LEN_C) & (sum_next == 11'd0);
    assign good_inc    = end_close & end_ok;
    assign close_cnt   = {1'b0, abort_close} + {1'b0, end_close};

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    // Frame FSM, reference generator state and the registered per-frame verdict
    always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
        if (!rst_n_1M024) begin
            state      <= ST_IDLE;
            lfsr       <= PRBS9_SEED;
            byte_cnt   <= 9'd0;
            err_sum    <= 11'd0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (compare_en) begin
                lfsr     <= gen_next;
                byte_cnt <= cnt_next;
                err_sum  <= sum_next;
                state    <= end_close ? ST_IDLE : ST_PAYLOAD;
            end
            if (abort_close | end_close) begin
                frame_done <= 1'b1;
                frame_ok   <= good_inc;
            end
        end
    end

    // Saturating statistics; clr wins over anything counted in the same cycle
    always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
        if (!rst_n_1M024) begin
            frame_cnt   <= '0;
            good_cnt    <= '0;
            err_bit_cnt <= '0;
        end else if (clr) begin
            frame_cnt   <= '0;
            good_cnt    <= '0;
            err_bit_cnt <= '0;
        end else begin
            if (compare_en) begin
                err_bit_cnt <= sat_add(err_bit_cnt, byte_errs);
            end
            if (close_cnt != 2'd0) begin
                frame_cnt <= sat_add(frame_cnt, {2'b00, close_cnt});
            end
            if (good_inc) begin
                good_cnt <= sat_add(good_cnt, 4'd1);
            end
        end
    end

`ifdef RX_FRAME_CHECKER_LOCK_EN
    localparam logic [7:0] LOCK_GOOD_C = 8'(LOCK_GOOD);
    localparam logic [7:0] LOCK_BAD_C  = 8'(LOCK_BAD);

    logic [7:0] good_streak;
    logic [7:0] bad_streak;
    logic [7:0] good_streak_next;
    logic [7:0] bad_streak_next;
    logic       lock_next;

    // Streak update; an aborted frame is applied before the frame ending this cycle
    always_comb begin
        good_streak_next = good_streak;
        bad_streak_next  = bad_streak;
        lock_next        = lock;
        if (abort_close) begin
            good_streak_next = 8'd0;
            bad_streak_next  = (bad_streak_next == 8'hFF) ? bad_streak_next : bad_streak_next + 8'd1;
            if (bad_streak_next >= LOCK_BAD_C) begin
                lock_next = 1'b0;
            end
        end
        if (end_close) begin
            if (end_ok) begin
                bad_streak_next  = 8'd0;
                good_streak_next = (good_streak_next == 8'hFF) ? good_streak_next : good_streak_next + 8'd1;
                if (good_streak_next >= LOCK_GOOD_C) begin
                    lock_next = 1'b1;
                end
            end else begin
                good_streak_next = 8'd0;
                bad_streak_next  = (bad_streak_next == 8'hFF) ? bad_streak_next : bad_streak_next + 8'd1;
                if (bad_streak_next >= LOCK_BAD_C) begin
                    lock_next = 1'b0;
                end
            end
        end
    end

    // Lock history registers; clr restarts the history including the flag
    always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
        if (!rst_n_1M024) begin
            good_streak <= 8'd0;
            bad_streak  <= 8'd0;
            lock        <= 1'b0;
        end else if (clr) begin
            good_streak <= 8'd0;
            bad_streak  <= 8'd0;
            lock        <= 1'b0;
        end else begin
            good_streak <= good_streak_next;
            bad_streak  <= bad_streak_next;
            lock        <= lock_next;
        end
    end
`else
    assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_rx_frame_checker.sv
// tb_rx_frame_checker: directed bench for rx_frame_checker with a verdict
// scoreboard. Lock expectations follow RX_FRAME_CHECKER_LOCK_EN.
module tb_rx_frame_checker;

    localparam int FRAME_LEN = 32;
    localparam int CNT_W     = 16;
    localparam int LOCK_GOOD = 4;
    localparam int LOCK_BAD  = 2;
    localparam int SAT_MAX   = 65535;
`ifdef RX_FRAME_CHECKER_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic             clk_1M024 = 1'b0;
    logic             rst_n_1M024;
    logic             clr;
    logic [7:0]       s_tdata;
    logic             s_tvalid;
    logic             s_tlast;
    logic             s_tuser;
    logic             frame_done;
    logic             frame_ok;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] err_bit_cnt;
    logic             lock;

    always #5 clk_1M024 = ~clk_1M024;

    rx_frame_checker #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W),
        .LOCK_GOOD (LOCK_GOOD),
        .LOCK_BAD  (LOCK_BAD)
    ) dut (
        .clk_1M024   (clk_1M024),
        .rst_n_1M024 (rst_n_1M024),
        .clr         (clr),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tuser     (s_tuser),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .frame_cnt   (frame_cnt),
        .good_cnt    (good_cnt),
        .err_bit_cnt (err_bit_cnt),
        .lock        (lock)
    );

    typedef struct {
        logic ok;
        int   fc;
        int   gc;
        int   ec;
        logic lk;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] prbs_ref [64];

    // Expected-behaviour model state
    bit   frame_open = 1'b0;
    int   m_cnt      = 0;
    int   m_ferr     = 0;
    int   e_fc       = 0;
    int   e_gc       = 0;
    int   e_ec       = 0;
    int   gs         = 0;
    int   bs         = 0;
    logic e_lock     = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int satInc(input int a, input int b);
        return (a + b > SAT_MAX) ? SAT_MAX : a + b;
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input logic v, input logic l, input logic u, input logic c);
        @(negedge clk_1M024);
        s_tdata  = d;
        s_tvalid = v;
        s_tlast  = l;
        s_tuser  = u;
        clr      = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic modelReset();
        frame_open = 1'b0;
        e_fc = 0; e_gc = 0; e_ec = 0; gs = 0; bs = 0; e_lock = 1'b0;
    endtask

    // Drives one valid byte and predicts its effect from the frame rules
    task automatic driveByte(input logic [7:0] d, input logic [7:0] ref_b, input logic l, input logic u, input logic c);
        int pc;
        bit do_close;
        bit vok;
        pc       = $countones(d ^ ref_b);
        do_close = 1'b0;
        vok      = 1'b0;
        if (u) begin
            e_ec = satInc(e_ec, pc);
            if (frame_open) do_close = 1'b1;
            frame_open = 1'b1;
            m_cnt      = 1;
            m_ferr     = pc;
            if (l) begin
                do_close   = 1'b1;
                vok        = (m_cnt == FRAME_LEN) && (m_ferr == 0);
                frame_open = 1'b0;
            end
        end else if (frame_open) begin
            e_ec = satInc(e_ec, pc);
            if (m_cnt == FRAME_LEN && !l) begin
                do_close   = 1'b1;
                frame_open = 1'b0;
            end else begin
                m_cnt++;
                m_ferr += pc;
                if (l) begin
                    do_close   = 1'b1;
                    vok        = (m_cnt == FRAME_LEN) && (m_ferr == 0);
                    frame_open = 1'b0;
                end
            end
        end
        if (c) begin
            e_fc = 0; e_gc = 0; e_ec = 0; gs = 0; bs = 0; e_lock = 1'b0;
        end else if (do_close) begin
            e_fc = satInc(e_fc, 1);
            if (vok) e_gc = satInc(e_gc, 1);
            if (LOCK_EN) begin
                if (vok) begin
                    bs = 0; gs++;
                    if (gs >= LOCK_GOOD) e_lock = 1'b1;
                end else begin
                    gs = 0; bs++;
                    if (bs >= LOCK_BAD) e_lock = 1'b0;
                end
            end
        end
        if (do_close) sb.push_back('{ok: vok, fc: e_fc, gc: e_gc, ec: e_ec, lk: e_lock});
        applyStimulus(d, 1'b1, l, u, c);
    endtask

    // PRBS frame of n bytes; xor_all hits every byte, p0/p1 add single-byte errors
    task automatic sendFrame(input int n, input bit with_last, input bit gaps, input logic [7:0] xor_all,
                             input int p0, input logic [7:0] m0, input int p1, input logic [7:0] m1,
                             input bit clr_on_close);
        logic [7:0] mask;
        bit         lst;
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) applyStimulus(8'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b0);
            mask = xor_all ^ ((i == p0) ? m0 : 8'h00) ^ ((i == p1) ? m1 : 8'h00);
            lst  = with_last && (i == n - 1);
            driveByte(prbs_ref[i] ^ mask, prbs_ref[i], lst, (i == 0), clr_on_close && lst);
        end
    endtask

    task automatic pulseClear();
        modelReset();
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
    endtask

    task automatic checkCounters(input string tag);
        idle(2);
        checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), e_fc);
        checkOutput({tag, "_good_cnt"}, 32'(good_cnt), e_gc);
        checkOutput({tag, "_err_bit_cnt"}, 32'(err_bit_cnt), e_ec);
        checkOutput({tag, "_lock"}, 32'(lock), 32'(e_lock));
    endtask

    // Verdict monitor: every frame_done must match the oldest expected close
    always @(negedge clk_1M024) begin
        if (rst_n_1M024 === 1'b1 && frame_done === 1'b1) begin
            checkOutput("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                checkOutput("sb_frame_ok", 32'(frame_ok), 32'(mon_e.ok));
                checkOutput("sb_frame_cnt", 32'(frame_cnt), mon_e.fc);
                checkOutput("sb_good_cnt", 32'(good_cnt), mon_e.gc);
                checkOutput("sb_err_bit_cnt", 32'(err_bit_cnt), mon_e.ec);
                checkOutput("sb_lock", 32'(lock), 32'(mon_e.lk));
            end
        end
    end

    initial begin
        bit   bits [512];
        int   drain;

        // Reference sequence from the recurrence s[n] = s[n-9] ^ s[n-5], all-ones start
        for (int n = 0; n < 512; n++) bits[n] = (n < 9) ? 1'b1 : (bits[n-9] ^ bits[n-5]);
        for (int k = 0; k < 64; k++)
            for (int b = 0; b < 8; b++) prbs_ref[k][7-b] = bits[8*k + b];
        $display("[TB] reference bytes 0x%02h 0x%02h", prbs_ref[0], prbs_ref[1]);

        rst_n_1M024 = 1'b0;
        clr = 1'b0; s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        repeat (3) @(negedge clk_1M024);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_frame_ok", 32'(frame_ok), 32'd0);
        rst_n_1M024 = 1'b1;
        checkCounters("reset");

        $display("[TB] clean frame");
        sendFrame(32, 1, 0, 8'h00, -1, 8'h00, -1, 8'h00, 0);
        checkCounters("clean");

        $display("[TB] bit errors");
        pulseClear();
        checkCounters("clr");
        sendFrame(32, 1, 0, 8'h00, 0, 8'h01, 5, 8'h81, 0);
        checkCounters("biterr");

        $display("[TB] short frame then good frame");
        pulseClear();
        sendFrame(31, 1, 0, 8'h00, -1, 8'h00, -1, 8'h00, 0);
        sendFrame(32, 1, 0, 8'h00, -1, 8'h00, -1, 8'h00, 0);
        checkCounters("short");

        $display("[TB] mid-frame tuser");
        pulseClear();
        sendFrame(10, 0, 0, 8'h00, -1, 8'h00, -1, 8'h00, 0);
        sendFrame(32, 1, 0, 8'h00, -1, 8'h00, -1, 8'h00, 0);
        checkCounters("midtuser");

        $display("[TB] overrun with gaps");
        pulseClear();
        sendFrame(33, 0, 1, 8'h00, -1, 8'h00, -1, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] junk;
            junk = 8'($urandom);
            driveByte(junk, ~junk, (i == 2), 1'b0, 1'b0);
        end
        checkCounters("overrun");
        sendFrame(32, 1, 0, 8'h00, -1, 8'h00, -1, 8'h00, 0);
        checkCounters("after_overrun");

        $display("[TB] reset mid-frame");
        sendFrame(10, 0, 0, 8'h00, -1, 8'h00, -1, 8'h00, 0);
        @(negedge clk_1M024);
        rst_n_1M024 = 1'b0;
        s_tvalid    = 1'b0;
        modelReset();
        repeat (2) @(negedge clk_1M024);
        rst_n_1M024 = 1'b1;
        for (int i = 10; i < 32; i++) driveByte(prbs_ref[i], prbs_ref[i], (i == 31), 1'b0, 1'b0);
        checkCounters("rst_mid");

        $display("[TB] lock and clr on close");
        pulseClear();
        for (int f = 0; f < 4; f++) sendFrame(32, 1, 0, 8'h00, -1, 8'h00, -1, 8'h00, 0);
        checkCounters("lock_up");
        for (int f = 0; f < 2; f++) sendFrame(31, 1, 0, 8'h00, -1, 8'h00, -1, 8'h00, 0);
        checkCounters("lock_down");
        sendFrame(32, 1, 0, 8'h00, -1, 8'h00, -1, 8'h00, 0);
        sendFrame(32, 1, 0, 8'h00, -1, 8'h00, -1, 8'h00, 1);
        checkCounters("clr_close");
        sendFrame(32, 1, 0, 8'h00, -1, 8'h00, -1, 8'h00, 0);
        checkCounters("after_clr");

        $display("[TB] error counter saturation");
        pulseClear();
        for (int f = 0; f < 256; f++) sendFrame(32, 1, 0, 8'hFF, -1, 8'h00, -1, 8'h00, 0);
        sendFrame(4, 1, 0, 8'h0F, -1, 8'h00, -1, 8'h00, 0);
        checkCounters("saturate");

        drain = 0;
        while (sb.size() != 0 && drain < 20) begin
            idle(1);
            drain++;
        end
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
